parity_frame_codec: RTL and testbench



---
 rtl/parity_frame_codec.sv | 98 +++++++++
 tb/tb_parity_frame_codec.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_codec.sv
// Parity framer (TX) and checker/stripper (RX) with registered valid/ready stages
// and a saturating parity-error counter. Optional macro: PARITY_DROP_ERR_EN.
module parity_frame_codec #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ODD       = 0,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enc_in_valid,
  output logic                 enc_in_ready,
  input  logic [DATA_W-1:0]    enc_in_data,
  output logic                 enc_out_valid,
  input  logic                 enc_out_ready,
  output logic [DATA_W:0]      enc_out_data,
  input  logic                 dec_in_valid,
  output logic                 dec_in_ready,
  input  logic [DATA_W:0]      dec_in_data,
  output logic                 dec_out_valid,
  input  logic                 dec_out_ready,
  output logic [DATA_W-1:0]    dec_out_data,
  output logic                 dec_out_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic SENSE = (ODD != 0);

  logic enc_p;
  logic enc_accept;
  logic dec_e;
  logic dec_accept;

  assign enc_p        = (^enc_in_data) ^ SENSE;
  assign enc_in_ready = !enc_out_valid || enc_out_ready;
  assign enc_accept   = enc_in_valid && enc_in_ready;

  assign dec_e        = (^dec_in_data) ^ SENSE;
  assign dec_in_ready = !dec_out_valid || dec_out_ready;
  assign dec_accept   = dec_in_valid && dec_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_out_valid <= 1'b0;
      enc_out_data  <= '0;
    end else if (enc_accept) begin
      enc_out_valid <= 1'b1;
      enc_out_data  <= {enc_p, enc_in_data};
    end else if (enc_out_ready) begin
      enc_out_valid <= 1'b0;
    end
  end

`ifdef PARITY_DROP_ERR_EN
  // Bad frames complete the input handshake but never reach the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_out_valid <= 1'b0;
      dec_out_data  <= '0;
    end else if (dec_accept) begin
      dec_out_valid <= !dec_e;
      if (!dec_e) begin
        dec_out_data <= dec_in_data[DATA_W-1:0];
      end
    end else if (dec_out_ready) begin
      dec_out_valid <= 1'b0;
    end
  end

  assign dec_out_err = 1'b0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_out_valid <= 1'b0;
      dec_out_data  <= '0;
      dec_out_err   <= 1'b0;
    end else if (dec_accept) begin
      dec_out_valid <= 1'b1;
      dec_out_data  <= dec_in_data[DATA_W-1:0];
      dec_out_err   <= dec_e;
    end else if (dec_out_ready) begin
      dec_out_valid <= 1'b0;
    end
  end
`endif

  // Clear wins over the old value but still counts a bad frame accepted on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= ERR_CNT_W'(dec_accept && dec_e);
    end else if (dec_accept && dec_e && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_frame_codec.sv
// Directed bench for parity_frame_codec: scoreboard queues filled on input transfers,
// drained on output transfers; honours PARITY_DROP_ERR_EN when defined.
module tb_parity_frame_codec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  int         checks = 0;
  int         errors = 0;

  logic       enc_in_valid, enc_in_ready, enc_out_valid, enc_out_ready;
  logic [7:0] enc_in_data;
  logic [8:0] enc_out_data;
  logic       dec_in_valid, dec_in_ready, dec_out_valid, dec_out_ready, dec_out_err;
  logic [8:0] dec_in_data;
  logic [7:0] dec_out_data;
  logic       err_clr;
  logic [1:0] err_count;

  logic       lb_in_valid, lb_in_ready, lb_v, lb_r, lb_out_valid, lb_out_ready, lb_out_err;
  logic [7:0] lb_in_data, lb_out_data, lb_err_count;
  logic [8:0] lb_d;
  logic       lb_clr = 1'b0;

  logic [8:0] q_enc[$];
  logic [8:0] q_dec[$];
  logic [7:0] q_lb[$];
  logic [8:0] exp9;
  logic [7:0] exp8;
  int         cnt_model = 0;

  parity_frame_codec #(.DATA_W(8), .ODD(0), .ERR_CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .enc_in_valid(enc_in_valid), .enc_in_ready(enc_in_ready), .enc_in_data(enc_in_data),
    .enc_out_valid(enc_out_valid), .enc_out_ready(enc_out_ready), .enc_out_data(enc_out_data),
    .dec_in_valid(dec_in_valid), .dec_in_ready(dec_in_ready), .dec_in_data(dec_in_data),
    .dec_out_valid(dec_out_valid), .dec_out_ready(dec_out_ready), .dec_out_data(dec_out_data),
    .dec_out_err(dec_out_err), .err_clr(err_clr), .err_count(err_count)
  );

  // Odd-parity instance with its encoder output looped into its decoder input.
  parity_frame_codec #(.DATA_W(8), .ODD(1), .ERR_CNT_W(8)) dut_odd (
    .clk(clk), .rst_n(rst_n),
    .enc_in_valid(lb_in_valid), .enc_in_ready(lb_in_ready), .enc_in_data(lb_in_data),
    .enc_out_valid(lb_v), .enc_out_ready(lb_r), .enc_out_data(lb_d),
    .dec_in_valid(lb_v), .dec_in_ready(lb_r), .dec_in_data(lb_d),
    .dec_out_valid(lb_out_valid), .dec_out_ready(lb_out_ready), .dec_out_data(lb_out_data),
    .dec_out_err(lb_out_err), .err_clr(lb_clr), .err_count(lb_err_count)
  );

  function automatic logic [8:0] good(input logic [7:0] d);
    return {^d, d};
  endfunction

  task automatic fail(input string tag, input logic [31:0] got, input logic [31:0] exp);
    errors++;
    $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      cnt_model = 0;
    end else begin
      checks++; if (err_count !== 2'(cnt_model)) fail("err_count_track", err_count, cnt_model);
      if (enc_out_valid && enc_out_ready) begin
        checks++; if ((q_enc.size() != 0) !== 1'b1) fail("enc_beat_expected", q_enc.size(), 1);
        if (q_enc.size() != 0) begin
          exp9 = q_enc.pop_front();
          checks++; if (enc_out_data !== exp9) fail("enc_data", enc_out_data, exp9);
        end
      end
      if (enc_in_valid && enc_in_ready) q_enc.push_back({^enc_in_data, enc_in_data});

      if (dec_out_valid && dec_out_ready) begin
        checks++; if ((q_dec.size() != 0) !== 1'b1) fail("dec_beat_expected", q_dec.size(), 1);
        if (q_dec.size() != 0) begin
          exp9 = q_dec.pop_front();
          checks++; if (dec_out_data !== exp9[7:0]) fail("dec_data", dec_out_data, exp9[7:0]);
          checks++; if (dec_out_err !== exp9[8]) fail("dec_err", dec_out_err, exp9[8]);
        end
      end
      if (dec_in_valid && dec_in_ready) begin
`ifdef PARITY_DROP_ERR_EN
        if (!(^dec_in_data)) q_dec.push_back({1'b0, dec_in_data[7:0]});
`else
        q_dec.push_back({^dec_in_data, dec_in_data[7:0]});
`endif
        if (err_clr) cnt_model = (^dec_in_data) ? 1 : 0;
        else if ((^dec_in_data) && cnt_model < 3) cnt_model++;
      end else if (err_clr) begin
        cnt_model = 0;
      end

      if (lb_v && lb_r) begin
        checks++; if ((^lb_d) !== 1'b1) fail("lb_wire_odd_parity", lb_d, 0);
      end
      if (lb_out_valid && lb_out_ready) begin
        checks++; if ((q_lb.size() != 0) !== 1'b1) fail("lb_beat_expected", q_lb.size(), 1);
        if (q_lb.size() != 0) begin
          exp8 = q_lb.pop_front();
          checks++; if (lb_out_data !== exp8) fail("lb_data", lb_out_data, exp8);
          checks++; if (lb_out_err !== 1'b0) fail("lb_err", lb_out_err, 0);
        end
      end
      if (lb_in_valid && lb_in_ready) q_lb.push_back(lb_in_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    enc_in_valid = 1'b0; enc_in_data = '0; enc_out_ready = 1'b0;
    dec_in_valid = 1'b0; dec_in_data = '0; dec_out_ready = 1'b0;
    err_clr = 1'b0;
    lb_in_valid = 1'b0; lb_in_data = '0; lb_out_ready = 1'b0;
    step(); step();
    checks++; if (enc_out_valid !== 1'b0) fail("rst_enc_out_valid", enc_out_valid, 0);
    checks++; if (dec_out_valid !== 1'b0) fail("rst_dec_out_valid", dec_out_valid, 0);
    checks++; if (dec_out_err !== 1'b0) fail("rst_dec_out_err", dec_out_err, 0);
    checks++; if (err_count !== 2'd0) fail("rst_err_count", err_count, 0);
    checks++; if (enc_out_data !== 9'h000) fail("rst_enc_out_data", enc_out_data, 0);
    checks++; if (dec_out_data !== 8'h00) fail("rst_dec_out_data", dec_out_data, 0);
    checks++; if (enc_in_ready !== 1'b1) fail("rst_enc_in_ready", enc_in_ready, 1);
    checks++; if (dec_in_ready !== 1'b1) fail("rst_dec_in_ready", dec_in_ready, 1);
    rst_n = 1'b1;
    step();

    // Exhaustive even-parity encode alongside odd-parity loopback
    enc_out_ready = 1'b1;
    lb_out_ready  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      enc_in_valid = 1'b1; enc_in_data = 8'(i);
      lb_in_valid  = 1'b1; lb_in_data  = 8'(i);
      step();
    end
    enc_in_valid = 1'b0; lb_in_valid = 1'b0;
    step(); step(); step();
    enc_in_valid = 1'b1; enc_in_data = 8'h03;
    step();
    checks++; if (enc_out_data !== 9'h003) fail("enc_0x03", enc_out_data, 9'h003);
    enc_in_data = 8'h07;
    step();
    checks++; if (enc_out_data !== 9'h107) fail("enc_0x07", enc_out_data, 9'h107);
    enc_in_valid = 1'b0;
    step();
    checks++; if (lb_err_count !== 8'h00) fail("lb_err_count_zero", lb_err_count, 0);
    checks++; if (q_lb.size() !== 0) fail("lb_queue_drained", q_lb.size(), 0);

    // Error injection: bit 8 of 9'h107 flipped
    dec_out_ready = 1'b1;
    dec_in_valid = 1'b1; dec_in_data = 9'h007;
    step();
    dec_in_valid = 1'b0;
`ifdef PARITY_DROP_ERR_EN
    checks++; if (dec_out_valid !== 1'b0) fail("inj_no_beat", dec_out_valid, 0);
`else
    checks++; if (dec_out_valid !== 1'b1) fail("inj_valid", dec_out_valid, 1);
    checks++; if (dec_out_data !== 8'h07) fail("inj_data", dec_out_data, 8'h07);
    checks++; if (dec_out_err !== 1'b1) fail("inj_err", dec_out_err, 1);
`endif
    checks++; if (err_count !== 2'd1) fail("inj_count", err_count, 1);
    step();

    // Saturation with a 2-bit counter
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err_count !== 2'd0) fail("sat_cleared", err_count, 0);
    for (int i = 0; i < 5; i++) begin
      exp8 = 8'(i + 16);
      dec_in_valid = 1'b1; dec_in_data = {~(^exp8), exp8};
      step();
      checks++; if (err_count !== 2'((i < 3) ? i + 1 : 3)) fail("sat_count", err_count, (i < 3) ? i + 1 : 3);
    end
    dec_in_data = 9'h007; err_clr = 1'b1;
    step();
    checks++; if (err_count !== 2'd1) fail("clr_with_bad", err_count, 1);
    dec_in_valid = 1'b0;
    step();
    checks++; if (err_count !== 2'd0) fail("clr_alone", err_count, 0);
    err_clr = 1'b0;
    step(); step();

    // Backpressure on the decoder output
    dec_out_ready = 1'b0;
    dec_in_valid = 1'b1; dec_in_data = good(8'hA0);
    step();
    dec_in_data = good(8'hA1);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (dec_in_ready !== 1'b0) fail("bp_in_ready_low", dec_in_ready, 0);
      checks++; if (dec_out_data !== 8'hA0) fail("bp_data_stable", dec_out_data, 8'hA0);
      checks++; if (dec_out_valid !== 1'b1) fail("bp_valid_held", dec_out_valid, 1);
    end
    dec_out_ready = 1'b1;
    step();
    for (int k = 2; k < 6; k++) begin
      dec_in_data = good(8'(8'hA0 + k));
      step();
      checks++; if (dec_in_ready !== 1'b1) fail("bp_release_ready", dec_in_ready, 1);
    end
    dec_in_valid = 1'b0;
    step(); step();
    checks++; if (q_dec.size() !== 0) fail("bp_queue_drained", q_dec.size(), 0);

    // Asynchronous reset with held words in both paths
    enc_out_ready = 1'b0; dec_out_ready = 1'b0;
    enc_in_valid = 1'b1; enc_in_data = 8'h55;
    dec_in_valid = 1'b1; dec_in_data = 9'h007;
    step();
    enc_in_valid = 1'b0; dec_in_valid = 1'b0;
    checks++; if (enc_out_valid !== 1'b1) fail("pre_rst_enc_valid", enc_out_valid, 1);
    checks++; if (err_count !== 2'd1) fail("pre_rst_count", err_count, 1);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (enc_out_valid !== 1'b0) fail("arst_enc_valid", enc_out_valid, 0);
    checks++; if (dec_out_valid !== 1'b0) fail("arst_dec_valid", dec_out_valid, 0);
    checks++; if (err_count !== 2'd0) fail("arst_count", err_count, 0);
    checks++; if (dec_out_err !== 1'b0) fail("arst_dec_err", dec_out_err, 0);
    q_enc.delete(); q_dec.delete(); q_lb.delete();
    step();
    #3 rst_n = 1'b1;
    step();
    checks++; if (enc_in_ready !== 1'b1) fail("post_rst_enc_ready", enc_in_ready, 1);
    checks++; if (dec_in_ready !== 1'b1) fail("post_rst_dec_ready", dec_in_ready, 1);
    checks++; if (enc_out_valid !== 1'b0) fail("post_rst_no_enc_beat", enc_out_valid, 0);
    checks++; if (dec_out_valid !== 1'b0) fail("post_rst_no_dec_beat", dec_out_valid, 0);
    enc_out_ready = 1'b1; dec_out_ready = 1'b1;
    step(); step();
    checks++; if (q_enc.size() !== 0) fail("end_enc_queue", q_enc.size(), 0);
    checks++; if (q_dec.size() !== 0) fail("end_dec_queue", q_dec.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
